// File: rtl/divider_datapath_if.sv
// Bundle between the restoring-divider controller (master) and its datapath (slave).
// restore_cnt exists only when DIV_RESTORE_CNT_EN is defined.
interface divider_datapath_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             load;
  logic             add;
  logic             shift;
  logic             inbit;
  logic [1:0]       sel;
  logic             sign;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             valid;
  logic             div_by_zero;
  logic             busy;
`ifdef DIV_RESTORE_CNT_EN
  logic [$clog2(WIDTH+1)-1:0] restore_cnt;
`endif

  modport master (
`ifdef DIV_RESTORE_CNT_EN
    input  restore_cnt,
`endif
    output start, dividend, divisor, load, add, shift, inbit, sel,
    input  sign, quotient, remainder, valid, div_by_zero, busy
  );

  modport slave (
`ifdef DIV_RESTORE_CNT_EN
    output restore_cnt,
`endif
    input  start, dividend, divisor, load, add, shift, inbit, sel,
    output sign, quotient, remainder, valid, div_by_zero, busy
  );
endinterface

// File: rtl/divider_datapath.sv
// Restoring-divider datapath: operand/remainder/quotient registers, trial subtract and step counter.
// Optional macro DIV_RESTORE_CNT_EN adds a count of rejected (restored) trials.
module divider_datapath #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  divider_datapath_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_q, q_q, d_q, quot_q, rem_q, r_next;
  logic [CW-1:0]    count_q;
  logic             busy_q, valid_q, dbz_q;
  logic [WIDTH:0]   p;
  logic [WIDTH+1:0] diff;
  logic             step, last;

  // Trial: shift the next dividend bit into the partial remainder and subtract the divisor.
  assign p        = {r_q, q_q[WIDTH-1]};
  assign diff     = {1'b0, p} - {2'b00, d_q};
  assign bus.sign = diff[WIDTH+1];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    r_next = r_q;
    step   = bus.shift && busy_q && !bus.start && !bus.load;
    last   = (count_q == CW'(WIDTH - 1));
    unique case (bus.sel)
      2'b11:   r_next = diff[WIDTH-1:0];
      2'b01:   r_next = p[WIDTH-1:0];
      2'b10:   r_next = '0;
      default: r_next = r_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else if (bus.start) begin
      q_q     <= bus.dividend;
      d_q     <= bus.divisor;
      r_q     <= '0;
      count_q <= '0;
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
      dbz_q   <= (bus.divisor == '0);
    end else if (bus.load) begin
      count_q <= '0;
      busy_q  <= 1'b0;
    end else if (step) begin
      r_q <= r_next;
      q_q <= {q_q[WIDTH-2:0], bus.inbit};
      if (last) begin
        quot_q  <= {q_q[WIDTH-2:0], bus.inbit};
        rem_q   <= r_next;
        valid_q <= 1'b1;
        busy_q  <= 1'b0;
        count_q <= '0;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.valid       = valid_q;
  assign bus.busy        = busy_q;
  assign bus.div_by_zero = dbz_q;

`ifdef DIV_RESTORE_CNT_EN
  logic [$clog2(WIDTH+1)-1:0] rc_q;

  // Steps stop once valid rises, so the count freezes alongside the results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rc_q <= '0;
    end else if (bus.start) begin
      rc_q <= '0;
    end else if (step && bus.add) begin
      rc_q <= rc_q + 1'b1;
    end
  end

  assign bus.restore_cnt = rc_q;
`else
  logic unused_add;
  assign unused_add = bus.add;
`endif
endmodule

// File: doc/divider_datapath.md
Name: divider_datapath

Overview:
- Datapath for the sequential restoring divider. It sits directly downstream of the divider controller and is driven by its load/add/shift/inbit/sel outputs.
- Feeds the trial-subtract sign back to the controller each cycle.
- Holds dividend, divisor, partial remainder and quotient registers, plus a step counter that ends the division after WIDTH steps and presents registered quotient/remainder with a valid flag.

Parameters:
- WIDTH, 8, operand width in bits (≥2); quotient and remainder are WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- start  input  1  begin new division; same signal the controller sees
- dividend  input  WIDTH  unsigned dividend, sampled when start=1
- divisor  input  WIDTH  unsigned divisor, sampled when start=1
- load  input  1  controller idle indication
- add  input  1  controller restore-step indication
- shift  input  1  step enable: shift partial remainder/quotient
- inbit  input  1  quotient bit shifted in on a step
- sel  input  2  remainder source select
- sign  output  1  MSB of current trial difference (1 = negative, reject)
- quotient  output  WIDTH  registered result quotient
- remainder  output  WIDTH  registered result remainder
- valid  output  1  result registers hold a completed division
- div_by_zero  output  1  divisor sampled at start was 0
- busy  output  1  division in progress

Behaviour:
- Reset (reset=0, async): R, Q, D, count, quotient, remainder = 0; valid, busy, div_by_zero = 0. sign follows from cleared registers (0).
- Combinational:
  - P = {R, Q[WIDTH-1]} (WIDTH+1 bits).
  - diff = {1'b0,P} − {2'b00,D} (WIDTH+2 bits).
  - sign = diff[WIDTH+1].
- start=1 at clock edge (highest priority, any state, including mid-division):
  - Q<=dividend, D<=divisor, R<=0, count<=0, busy<=1, valid<=0.
  - div_by_zero<=(divisor==0).
- load=1, start=0: hold operands; count<=0, busy<=0. valid and result registers unchanged.
- Step: shift=1 and busy=1 and start=0 and load=0.
  - R <= sel==2'b11 ? diff[WIDTH-1:0] : sel==2'b01 ? P[WIDTH-1:0] : sel==2'b10 ? 0 : R.
  - Q <= {Q[WIDTH-2:0], inbit}.
  - count <= count+1.
- Final step (count==WIDTH-1):
  - quotient <= {Q[WIDTH-2:0], inbit}; remainder <= the new R value.
  - valid<=1, busy<=0, count<=0.
- shift=1 while busy=0: ignored. Results and valid hold until the next start.
- sel==2'b00 on a step: R held; Q still shifts (illegal from controller; defined for determinism).
- add has no datapath effect unless the optional feature is compiled in.
- Latency: controller uses 2 cycles per step (trial, commit). valid rises 2·WIDTH+1 clocks after the start edge.
- Divide by zero: all trials accept (sign=0) → quotient = all ones, remainder = dividend; div_by_zero=1.
- count width: $clog2(WIDTH). Never exceeds WIDTH-1 (wraps to 0 at completion).
- Reset mid-division: immediate return to reset values; no partial result is exposed.

Optional Feature:
- Macro DIV_RESTORE_CNT_EN.
- Defined: adds output restore_cnt, width $clog2(WIDTH+1).
  - Cleared on start and on reset.
  - Increments on each step with add=1.
  - Frozen with the results when valid rises (counts rejected trials).
- Undefined: port absent; add input unused.

Test Plan:
- Reset asserted mid-division at step 3 → all outputs 0 asynchronously; after release, load=1 idle keeps valid=0.
- dividend=100, divisor=7, start pulse, controller loop → valid after 17 clocks; quotient=14, remainder=2, div_by_zero=0.
- dividend=5, divisor=9 → quotient=0, remainder=5. With DIV_RESTORE_CNT_EN, restore_cnt=8.
- dividend=255, divisor=1 → quotient=255, remainder=0; sign=0 on the final trial.
- dividend=37, divisor=0 → quotient=255, remainder=37, div_by_zero=1, valid=1.
- start re-asserted at step 4 of 100/7 with new operands 200/13 → valid drops immediately; result quotient=15, remainder=5 after a fresh 17 clocks.
